braun_dot_accumulator: RTL

- Sequential stage directly downstream of the 4x4 Braun array multiplier.
- Consumes a stream of 8-bit unsigned products with a valid/ready handshake.
- Sums LEN consecutive products into one dot-product result.
- Presents each result on a valid/ready output interface with a sticky overflow flag.
- Turns the combinational multiplier into a usable multiply-accumulate path.

---
 rtl/braun_dot_accumulator_pkg.sv | 15 +
 rtl/braun_acc_add.sv | 28 ++
 rtl/braun_dot_accumulator.sv | 102 ++++++++++
 3 files changed

// File: rtl/braun_dot_accumulator_pkg.sv
// Shared types and width constants for the Braun multiplier accumulate path
// (package braun_pkg).
package braun_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam int PROD_W_DEF = 8;
  localparam int ACC_W_DEF  = 16;

  // Width that holds product counts 0..len inclusive.
  function automatic int cnt_w(input int len);
    return (len < 1) ? 1 : $clog2(len + 1);
  endfunction

endpackage

// File: rtl/braun_acc_add.sv
// Accumulator adder with carry-out. Define BRAUN_ACC_SATURATE_EN to clamp the
// sum at all-ones on carry instead of wrapping.
module braun_acc_add
  import braun_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic [ACC_W-1:0]  a,
  input  logic [PROD_W-1:0] b,
  output logic [ACC_W-1:0]  sum,
  output logic              carry
);

  logic [ACC_W:0] full;

  always_comb begin
    full  = {1'b0, a} + {{(ACC_W + 1 - PROD_W){1'b0}}, b};
    carry = full[ACC_W];
`ifdef BRAUN_ACC_SATURATE_EN
    // Once clamped, any further non-zero product carries again and re-clamps.
    sum   = carry ? {ACC_W{1'b1}} : full[ACC_W-1:0];
`else
    sum   = full[ACC_W-1:0];
`endif
  end

endmodule

// File: rtl/braun_dot_accumulator.sv
// Sums LEN unsigned products into one dot product with valid/ready in and out.
// Optional BRAUN_ACC_SATURATE_EN selects saturating accumulation in braun_acc_add.
module braun_dot_accumulator
  import braun_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int LEN    = 4,
  localparam int CNT_W = cnt_w(LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic [PROD_W-1:0] prod,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res,
  output logic              ovf,
  output logic [CNT_W-1:0]  count
);

  localparam logic [CNT_W-1:0] LEN_C = CNT_W'(LEN);

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc, res_r, add_a, add_sum;
  logic             add_carry, ovf_r, res_valid_r;
  logic [CNT_W-1:0] count_r, count_inc;
  logic             take, give, last;

  assign prod_ready = (state != DONE);
  assign take       = prod_valid && prod_ready;
  assign give       = res_valid_r && res_ready;

  // A new dot product starts from zero, so IDLE feeds 0 into the adder.
  assign add_a     = (state == IDLE) ? '0 : acc;
  assign count_inc = (state == IDLE) ? CNT_W'(1) : count_r + CNT_W'(1);
  assign last      = (count_inc == LEN_C);

  braun_acc_add #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_add (
    .a     (add_a),
    .b     (prod),
    .sum   (add_sum),
    .carry (add_carry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, ACCUM: if (take) state_nxt = last ? DONE : ACCUM;
        DONE:        if (give) state_nxt = IDLE;
        default:     state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc         <= '0;
      count_r     <= '0;
      ovf_r       <= 1'b0;
      res_r       <= '0;
      res_valid_r <= 1'b0;
    end else if (clr) begin
      acc         <= '0;
      count_r     <= '0;
      ovf_r       <= 1'b0;
      res_r       <= '0;
      res_valid_r <= 1'b0;
    end else if (take) begin
      acc     <= add_sum;
      count_r <= count_inc;
      // Sticky within a dot product; the first accept clears the previous flag.
      ovf_r   <= ((state != IDLE) && ovf_r) || add_carry;
      if (last) begin
        res_r       <= add_sum;
        res_valid_r <= 1'b1;
      end
    end else if (give) begin
      res_valid_r <= 1'b0;
      count_r     <= '0;
    end
  end

  assign res_valid = res_valid_r;
  assign res       = res_r;
  assign ovf       = ovf_r;
  assign count     = count_r;

endmodule
